// File: rtl/csr_access_unit_pkg.sv
// Shared types and decode helpers for the CSR access unit.
package csr_access_unit_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned F3_W   = 3;
  localparam int unsigned OP_W   = 2;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_READ  = 2'b01,
    S_WRITE = 2'b10,
    S_RESP  = 2'b11
  } state_e;

  typedef struct packed {
    logic [F3_W-1:0]   funct3;
    logic [ADDR_W-1:0] csr_addr;
    logic [REG_W-1:0]  rs1_idx;
    logic [REG_W-1:0]  rd;
  } csr_req_t;

  function automatic logic f_is_rw(input logic [F3_W-1:0] f3);
    return f3[1:0] == CSR_RW;
  endfunction

  // CSRRW/CSRRWI with rd==x0 must not produce a read side effect
  function automatic logic f_rd_needed(input logic [F3_W-1:0] f3, input logic [REG_W-1:0] rd);
    return !(f_is_rw(f3) && rd == '0);
  endfunction

  // Set/clear forms with a zero operand must not produce a write side effect
  function automatic logic f_wr_needed(input logic [F3_W-1:0] f3, input logic [REG_W-1:0] idx);
    return f_is_rw(f3) || idx != '0;
  endfunction

  function automatic logic f_illegal(input logic [F3_W-1:0] f3, input logic [ADDR_W-1:0] addr,
                                     input logic [REG_W-1:0] idx, input logic check_ro);
    return (f3[1:0] == CSR_NONE) ||
           (check_ro && addr[ADDR_W-1:ADDR_W-2] == 2'b11 && f_wr_needed(f3, idx));
  endfunction

endpackage

// File: rtl/csr_access_unit.sv
// Initiator for the CSR file port: sequences read then write for one Zicsr instruction
// and hands the old CSR value to writeback.
module csr_access_unit
  import csr_access_unit_pkg::*;
#(
  parameter int unsigned XLEN     = 64,
  parameter bit          CHECK_RO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [F3_W-1:0]   req_funct3,
  input  logic [ADDR_W-1:0] req_csr_addr,
  input  logic [XLEN-1:0]   req_rs1_data,
  input  logic [REG_W-1:0]  req_rs1_idx,
  input  logic [REG_W-1:0]  req_rd,
  output logic [ADDR_W-1:0] csr_addr,
  output logic              csr_rena,
  output logic              csr_wena,
  output logic [OP_W-1:0]   csr_op,
  output logic [XLEN-1:0]   csr_wdata,
  input  logic [XLEN-1:0]   csr_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [REG_W-1:0]  rsp_rd,
  output logic              rsp_wen,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_illegal
);

  state_e           state_q, state_d;
  csr_req_t         req_q;
  logic [XLEN-1:0]  rs1_q;
  logic [XLEN-1:0]  old_q;
  logic             illegal_q;
  logic             rd_needed_q;
  logic             wr_needed_q;
  logic             accept;
  logic             in_resp;
  logic             in_write;

  assign accept   = (state_q == S_IDLE) && req_valid && !flush;
  assign in_resp  = (state_q == S_RESP);
  assign in_write = (state_q == S_WRITE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Flush overrides every transition, including a pending writeback handshake
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (req_valid)
                   state_d = f_illegal(req_funct3, req_csr_addr, req_rs1_idx, CHECK_RO) ? S_RESP : S_READ;
        S_READ:  state_d = S_WRITE;
        S_WRITE: state_d = S_RESP;
        S_RESP:  if (rsp_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q       <= '0;
      rs1_q       <= '0;
      old_q       <= '0;
      illegal_q   <= 1'b0;
      rd_needed_q <= 1'b0;
      wr_needed_q <= 1'b0;
    end else if (accept) begin
      req_q       <= '{funct3: req_funct3, csr_addr: req_csr_addr, rs1_idx: req_rs1_idx, rd: req_rd};
      rs1_q       <= req_rs1_data;
      old_q       <= '0;
      illegal_q   <= f_illegal(req_funct3, req_csr_addr, req_rs1_idx, CHECK_RO);
      rd_needed_q <= f_rd_needed(req_funct3, req_rd);
      wr_needed_q <= f_wr_needed(req_funct3, req_rs1_idx);
    end else if (state_q == S_READ) begin
      old_q <= rd_needed_q ? csr_rdata : '0;
    end
  end

  // CSR port is quiet outside READ/WRITE; csr_rdata is only meaningful during READ
  always_comb begin
    req_ready   = rst && (state_q == S_IDLE) && !flush;
    csr_addr    = (state_q == S_READ || in_write) ? req_q.csr_addr : '0;
    csr_rena    = (state_q == S_READ) && rd_needed_q;
    csr_wena    = in_write && wr_needed_q && !flush;
    csr_op      = in_write ? req_q.funct3[1:0] : OP_W'(CSR_NONE);
    csr_wdata   = '0;
    if (in_write)
      csr_wdata = req_q.funct3[2] ? XLEN'(req_q.rs1_idx) : rs1_q;
    rsp_valid   = in_resp && !flush;
    rsp_rd      = in_resp ? req_q.rd : '0;
    rsp_wen     = in_resp && (req_q.rd != '0) && !illegal_q;
    rsp_data    = in_resp ? old_q : '0;
    rsp_illegal = in_resp && illegal_q;
  end

endmodule

// File: tb/tb_csr_access_unit.sv
// Randomized scoreboard bench for csr_access_unit with an attached CSR storage model.
module tb_csr_access_unit;
  import csr_access_unit_pkg::*;

  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            flush = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic [2:0]      req_funct3 = '0;
  logic [11:0]     req_csr_addr = '0;
  logic [XLEN-1:0] req_rs1_data = '0;
  logic [4:0]      req_rs1_idx = '0;
  logic [4:0]      req_rd = '0;
  logic [11:0]     csr_addr;
  logic            csr_rena;
  logic            csr_wena;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            rsp_valid;
  logic            rsp_ready = 1'b0;
  logic [4:0]      rsp_rd;
  logic            rsp_wen;
  logic [XLEN-1:0] rsp_data;
  logic            rsp_illegal;

  csr_access_unit #(.XLEN(XLEN), .CHECK_RO(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_csr_addr(req_csr_addr), .req_rs1_data(req_rs1_data), .req_rs1_idx(req_rs1_idx),
    .req_rd(req_rd), .csr_addr(csr_addr), .csr_rena(csr_rena), .csr_wena(csr_wena),
    .csr_op(csr_op), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_wen(rsp_wen),
    .rsp_data(rsp_data), .rsp_illegal(rsp_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic            wen;
    logic [XLEN-1:0] data;
    logic            illegal;
    int              acc;
    int              lat;
  } exp_t;

  exp_t            sb[$];
  int              tests = 0;
  int              fails = 0;
  int              cyc = 0;
  int              rena_cnt = 0;
  int              wena_cnt = 0;
  bit              hold = 1'b0;
  int              force_stall = -1;
  logic [XLEN-1:0] csr_mem [4096];
  logic [XLEN-1:0] ref_mem [4096];
  bit              mem_ready = 1'b0;
  logic [11:0]     addr_list [8];

  function automatic logic [XLEN-1:0] seed(input logic [11:0] a);
    return {20'hA5A5A, a, 20'h5C3E1, a};
  endfunction

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // CSR block stand-in: combinational read, op applied on the clock edge
  assign csr_rdata = csr_rena ? csr_mem[csr_addr] : '0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) csr_mem[i] <= seed(12'(i));
      mem_ready <= 1'b1;
    end else if (csr_wena) begin
      case (csr_op)
        2'b01:   csr_mem[csr_addr] <= csr_wdata;
        2'b10:   csr_mem[csr_addr] <= csr_mem[csr_addr] | csr_wdata;
        2'b11:   csr_mem[csr_addr] <= csr_mem[csr_addr] & ~csr_wdata;
        default: ;
      endcase
    end
  end

  // Response monitor: pops the scoreboard on each accepted response
  bit              seen = 1'b0;
  int              stall_cnt = 0;
  int              stall_n = 0;
  logic [XLEN-1:0] snap_data;
  logic [6:0]      snap_ctl;
  exp_t            me;

  always @(negedge clk) begin
    if (!rst) begin
      rsp_ready = 1'b0;
      seen = 1'b0;
    end else begin
      rena_cnt += int'(csr_rena);
      wena_cnt += int'(csr_wena);
      chk("rena_wena_exclusive", 64'(csr_rena & csr_wena), 64'd0);
      if (rsp_valid && !hold) begin
        if (!seen) begin
          seen = 1'b1;
          stall_cnt = 0;
          stall_n = (force_stall >= 0) ? force_stall : int'($urandom_range(0, 3));
          snap_data = rsp_data;
          snap_ctl = {rsp_rd, rsp_wen, rsp_illegal};
          if (sb.size() == 0) chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
          else chk("latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
        end else begin
          chk("stall_data_stable", rsp_data, snap_data);
          chk("stall_ctl_stable", 64'({rsp_rd, rsp_wen, rsp_illegal}), 64'(snap_ctl));
          chk("stall_req_ready", 64'(req_ready), 64'd0);
          chk("stall_csr_idle", 64'({csr_rena, csr_wena, csr_addr}), 64'd0);
        end
        if (stall_cnt >= stall_n) begin
          rsp_ready = 1'b1;
          seen = 1'b0;
          if (sb.size() != 0) begin
            me = sb.pop_front();
            chk("rsp_rd", 64'(rsp_rd), 64'(me.rd));
            chk("rsp_wen", 64'(rsp_wen), 64'(me.wen));
            chk("rsp_data", rsp_data, me.data);
            chk("rsp_illegal", 64'(rsp_illegal), 64'(me.illegal));
          end
        end else begin
          rsp_ready = 1'b0;
          stall_cnt++;
        end
      end else begin
        rsp_ready = 1'b0;
        if (!rsp_valid) seen = 1'b0;
      end
    end
  end

  // fl: 0 none, 1/2/3 flush during the 1st/2nd/3rd cycle after acceptance
  task automatic issue(input logic [2:0] f3, input logic [11:0] addr, input logic [63:0] rs1,
                       input logic [4:0] idx, input logic [4:0] rd, input int fl, input int stall);
    logic rw, rdn, wrn, ill, done;
    logic [XLEN-1:0] opnd, old, nv;
    exp_t e;
    int r0, w0, k, exp_w;
    rw   = (f3[1:0] == 2'b01);
    rdn  = !(rw && rd == 5'd0);
    wrn  = rw || (idx != 5'd0);
    ill  = (f3[1:0] == 2'b00) || (addr[11:10] == 2'b11 && wrn);
    k    = (ill && fl > 1) ? 1 : fl;
    old  = ref_mem[addr];
    opnd = f3[2] ? {59'd0, idx} : rs1;
    case (f3[1:0])
      2'b01:   nv = opnd;
      2'b10:   nv = old | opnd;
      2'b11:   nv = old & ~opnd;
      default: nv = old;
    endcase
    exp_w = (!ill && wrn && (k == 0 || k == 3)) ? 1 : 0;
    if (exp_w == 1) ref_mem[addr] = nv;
    e.rd = rd;
    e.wen = (rd != 5'd0) && !ill;
    e.data = (ill || !rdn) ? '0 : old;
    e.illegal = ill;
    e.lat = ill ? 1 : 3;
    r0 = rena_cnt;
    w0 = wena_cnt;
    hold = (k != 0);
    force_stall = stall;
    @(posedge clk); #1;
    req_valid = 1'b1; req_funct3 = f3; req_csr_addr = addr;
    req_rs1_data = rs1; req_rs1_idx = idx; req_rd = rd;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin done = 1'b1; break; end
    end
    if (!done) begin
      chk("accept_timeout", 64'(done), 64'd1);
      req_valid = 1'b0;
      hold = 1'b0;
      return;
    end
    e.acc = cyc;
    if (k == 0) sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_funct3 = 3'($urandom); req_csr_addr = 12'($urandom);
    req_rs1_data = {$urandom, $urandom}; req_rs1_idx = 5'($urandom); req_rd = 5'($urandom);
    if (k != 0) begin
      repeat (k - 1) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(negedge clk);
      chk("flush_wena", 64'(csr_wena), 64'd0);
      chk("flush_req_ready", 64'(req_ready), 64'd0);
      chk("flush_rsp_valid", 64'(rsp_valid), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("post_flush_ready", 64'(req_ready), 64'd1);
    end
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && req_ready) begin done = 1'b1; break; end
    end
    chk("complete_timeout", 64'(done), 64'd1);
    chk("csr_value", csr_mem[addr], ref_mem[addr]);
    chk("wena_count", 64'(wena_cnt - w0), 64'(exp_w));
    if (k == 0) chk("rena_count", 64'(rena_cnt - r0), 64'((!ill && rdn) ? 1 : 0));
    hold = 1'b0;
    force_stall = -1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    logic [2:0] f3;
    logic [11:0] a;
    addr_list[0] = 12'h340; addr_list[1] = 12'h341; addr_list[2] = 12'hB00; addr_list[3] = 12'h300;
    addr_list[4] = 12'hC00; addr_list[5] = 12'hC01; addr_list[6] = 12'h7C0; addr_list[7] = 12'hF14;
    for (int i = 0; i < 4096; i++) ref_mem[i] = seed(12'(i));

    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_csr", 64'({csr_rena, csr_wena, csr_op, csr_addr}), 64'd0);
    chk("reset_wdata", csr_wdata, 64'd0);
    chk("reset_rsp", 64'({rsp_valid, rsp_rd, rsp_wen, rsp_illegal}), 64'd0);
    chk("reset_rsp_data", rsp_data, 64'd0);

    issue(3'b010, 12'hB00, 64'h0123, 5'd0, 5'd5, 0, -1);        // CSRRS x5, x0: read only
    issue(3'b001, 12'hB00, 64'hDEAD, 5'd3, 5'd0, 0, -1);        // CSRRW x0: write only
    issue(3'b010, 12'hB00, 64'h0, 5'd0, 5'd6, 0, -1);           // read back 0xDEAD
    issue(3'b111, 12'hB00, 64'hFFFF, 5'h0F, 5'd7, 0, -1);       // CSRRCI clears low nibble
    issue(3'b010, 12'hB00, 64'h0, 5'd0, 5'd8, 0, -1);
    issue(3'b100, 12'h340, 64'h55, 5'd2, 5'd9, 0, -1);          // illegal funct3
    issue(3'b000, 12'h340, 64'h55, 5'd2, 5'd9, 0, -1);
    issue(3'b001, 12'hC00, 64'h77, 5'd1, 5'd10, 0, -1);         // write to read-only space
    issue(3'b010, 12'hC00, 64'h0, 5'd0, 5'd11, 0, -1);          // read-only space read is fine
    issue(3'b001, 12'h340, 64'hCAFE, 5'd1, 5'd3, 2, -1);        // flush in WRITE
    issue(3'b010, 12'h340, 64'h0F0, 5'd1, 5'd3, 1, -1);         // flush in READ
    issue(3'b011, 12'h341, 64'h0F0, 5'd1, 5'd3, 3, -1);         // flush in RESP: write kept
    issue(3'b100, 12'h341, 64'h0, 5'd1, 5'd3, 1, -1);           // flush illegal in RESP
    issue(3'b110, 12'h300, 64'h0, 5'h1A, 5'd12, 0, 5);          // 5-cycle writeback stall
    issue(3'b010, 12'h300, 64'h0, 5'd0, 5'd13, 0, 0);

    // Async reset in the WRITE cycle must suppress the write
    w0 = wena_cnt;
    @(posedge clk); #1;
    req_valid = 1'b1; req_funct3 = 3'b001; req_csr_addr = 12'h341;
    req_rs1_data = 64'h1111_2222_3333_4444; req_rs1_idx = 5'd9; req_rd = 5'd4;
    @(negedge clk);
    chk("rstmid_accept", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstmid_wena", 64'(csr_wena), 64'd0);
    chk("rstmid_addr", 64'(csr_addr), 64'd0);
    chk("rstmid_rsp_valid", 64'(rsp_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_ready", 64'(req_ready), 64'd1);
    repeat (4) @(negedge clk);
    chk("rstmid_no_write", csr_mem[12'h341], ref_mem[12'h341]);
    chk("rstmid_wena_count", 64'(wena_cnt - w0), 64'd0);

    for (int n = 0; n < 150; n++) begin
      f3 = 3'($urandom);
      a = addr_list[$urandom_range(0, 7)];
      issue(f3, a, {$urandom, $urandom},
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 3)) : 0, -1);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
